// File: rtl/mux_buffered.sv
// N-way data mux joining an index channel with the selected input into a 2-slot elastic output stage.
// Latency: 1 cycle fire-to-outs_valid. Backpressure: readies depend only on the registered skid-full flag,
// never on outs_ready. Optional MUX_SEL_TAG_EN adds an outs_index tag stored alongside each token.
module mux_buffered #(
  parameter int SIZE        = 2,
  parameter int DATA_TYPE   = 32,
  parameter int SELECT_TYPE = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SIZE*DATA_TYPE-1:0]   ins,
  input  logic [SIZE-1:0]             ins_valid,
  output logic [SIZE-1:0]             ins_ready,
  input  logic [SELECT_TYPE-1:0]      index,
  input  logic                        index_valid,
  output logic                        index_ready,
  output logic [DATA_TYPE-1:0]        outs,
  output logic                        outs_valid,
  input  logic                        outs_ready
`ifdef MUX_SEL_TAG_EN
  ,
  output logic [SELECT_TYPE-1:0]      outs_index
`endif
);

  logic                 m_full_q, m_full_d;
  logic                 s_full_q, s_full_d;
  logic [DATA_TYPE-1:0] m_dat_q, m_dat_d;
  logic [DATA_TYPE-1:0] s_dat_q, s_dat_d;
`ifdef MUX_SEL_TAG_EN
  logic [SELECT_TYPE-1:0] m_tag_q, m_tag_d;
  logic [SELECT_TYPE-1:0] s_tag_q, s_tag_d;
`endif

  logic                 in_range;
  logic                 sel_vld;
  logic [DATA_TYPE-1:0] sel_dat;
  logic                 buf_ready;
  logic                 fire;
  logic                 drain;
  logic                 m_free;

  // buf_ready is a pure function of registered state, keeping outs_ready off the input ready path
  assign buf_ready = ~s_full_q;
  assign in_range  = ({1'b0, index} < (SELECT_TYPE + 1)'(SIZE));

  always_comb begin
    sel_dat = '0;
    sel_vld = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      if (index == SELECT_TYPE'(i)) begin
        sel_dat = ins[i*DATA_TYPE +: DATA_TYPE];
        sel_vld = ins_valid[i];
      end
    end
  end

  assign fire        = index_valid & in_range & sel_vld & buf_ready;
  assign index_ready = fire | (index_valid & ~in_range);
  assign drain       = m_full_q & outs_ready;
  assign m_free      = ~m_full_q | drain;

  always_comb begin
    ins_ready = '0;
    for (int i = 0; i < SIZE; i++) begin
      ins_ready[i] = fire && (index == SELECT_TYPE'(i));
    end
  end

  always_comb begin
    m_full_d = m_full_q;
    s_full_d = s_full_q;
    m_dat_d  = m_dat_q;
    s_dat_d  = s_dat_q;
`ifdef MUX_SEL_TAG_EN
    m_tag_d  = m_tag_q;
    s_tag_d  = s_tag_q;
`endif
    // A full skid slot blocks fire, so promotion and capture never collide
    if (drain && s_full_q) begin
      m_dat_d  = s_dat_q;
      s_full_d = 1'b0;
`ifdef MUX_SEL_TAG_EN
      m_tag_d  = s_tag_q;
`endif
    end else if (fire && m_free) begin
      m_full_d = 1'b1;
      m_dat_d  = sel_dat;
`ifdef MUX_SEL_TAG_EN
      m_tag_d  = index;
`endif
    end else if (drain) begin
      m_full_d = 1'b0;
    end
    if (fire && !m_free) begin
      s_full_d = 1'b1;
      s_dat_d  = sel_dat;
`ifdef MUX_SEL_TAG_EN
      s_tag_d  = index;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_full_q <= 1'b0;
      s_full_q <= 1'b0;
      m_dat_q  <= '0;
      s_dat_q  <= '0;
`ifdef MUX_SEL_TAG_EN
      m_tag_q  <= '0;
      s_tag_q  <= '0;
`endif
    end else begin
      m_full_q <= m_full_d;
      s_full_q <= s_full_d;
      m_dat_q  <= m_dat_d;
      s_dat_q  <= s_dat_d;
`ifdef MUX_SEL_TAG_EN
      m_tag_q  <= m_tag_d;
      s_tag_q  <= s_tag_d;
`endif
    end
  end

  assign outs       = m_dat_q;
  assign outs_valid = m_full_q;
`ifdef MUX_SEL_TAG_EN
  assign outs_index = m_tag_q;
`endif

endmodule
